// File: rtl/brisc_pkg.sv
// Shared types and constants for the brisc pipeline memory stage.
package brisc_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned MEM_TIMEOUT = 64;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_RESP
  } mem_state_e;

  typedef enum logic [4:0] {
    NOP = 5'd0,
    ADD = 5'd1,
    SUB = 5'd2,
    LW  = 5'd8,
    SW  = 5'd9,
    LB  = 5'd10,
    LBU = 5'd11,
    SB  = 5'd12
  } instr_e;

endpackage

// File: rtl/load_align.sv
// Byte select and sign/zero extension of load data.
// Only built with MEM_BYTE_EN; without it the memory stage passes load data straight through.
`ifdef MEM_BYTE_EN
module load_align
  import brisc_pkg::*;
(
  input  logic [XLEN-1:0] i_rdata,
  input  logic [1:0]      i_off,
  input  logic            i_byte,
  input  logic            i_sext,
  output logic [XLEN-1:0] o_data
);

  logic [7:0] w_byte;

  always_comb begin
    case (i_off)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    if (!i_byte) begin
      o_data = i_rdata;
    end else if (i_sext) begin
      o_data = {{(XLEN-8){w_byte[7]}}, w_byte};
    end else begin
      o_data = {{(XLEN-8){1'b0}}, w_byte};
    end
  end

endmodule
`endif

// File: rtl/mem_stage.sv
// Pipeline memory stage: issues loads/stores to the data cache and stalls upstream while busy.
// Optional byte accesses (LB/LBU/SB) are enabled with MEM_BYTE_EN.
module mem_stage
  import brisc_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = MEM_TIMEOUT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      instr_in,
  input  logic [XLEN-1:0] alu_res,
  input  logic [XLEN-1:0] rs2_data,
  output logic            dc_req_valid,
  output logic            dc_req_we,
  output logic [XLEN-1:0] dc_req_addr,
  output logic [XLEN-1:0] dc_req_wdata,
  output logic [3:0]      dc_req_be,
  input  logic            dc_req_ready,
  input  logic            dc_resp_valid,
  input  logic [XLEN-1:0] dc_resp_rdata,
  output logic            stall_mem,
  output logic [XLEN-1:0] wb_data,
  output logic [4:0]      instr_out,
  output logic            misaligned,
  output logic            mem_err
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  mem_state_e      r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [XLEN-1:0] r_addr, r_wdata, r_wb_data, w_wb_nxt;
  logic [3:0]      r_be;
  logic [4:0]      r_instr, r_instr_out, w_instr_out_nxt;
  logic            r_we, r_misaligned, r_mem_err;
  logic            w_mis_nxt, w_err_nxt, w_latch, w_done;

  logic            w_is_word, w_is_byte, w_is_store, w_misalign, w_issue;
  logic [3:0]      w_be;
  logic [XLEN-1:0] w_wdata, w_load_data;

  // Instruction decode for the access presented by execute
  always_comb begin
    w_is_word  = (instr_in == LW) || (instr_in == SW);
`ifdef MEM_BYTE_EN
    w_is_byte  = (instr_in == LB) || (instr_in == LBU) || (instr_in == SB);
    w_be       = w_is_byte ? 4'(4'b0001 << alu_res[1:0]) : 4'b1111;
    w_wdata    = (instr_in == SB) ? {(XLEN/8){rs2_data[7:0]}} : rs2_data;
`else
    w_is_byte  = 1'b0;
    w_be       = 4'b1111;
    w_wdata    = rs2_data;
`endif
    w_is_store = (instr_in == SW) || (w_is_byte && (instr_in == SB));
    w_misalign = w_is_word && (alu_res[1:0] != 2'b00);
    w_issue    = (w_is_word && !w_misalign) || w_is_byte;
  end

`ifdef MEM_BYTE_EN
  logic w_ld_byte, w_ld_sext;
  assign w_ld_byte = (r_instr == LB) || (r_instr == LBU);
  assign w_ld_sext = (r_instr == LB);

  load_align u_load_align (
    .i_rdata (dc_resp_rdata),
    .i_off   (r_addr[1:0]),
    .i_byte  (w_ld_byte),
    .i_sext  (w_ld_sext),
    .o_data  (w_load_data)
  );
`else
  assign w_load_data = dc_resp_rdata;
`endif

  // Next-state and output logic; stall drops in the cycle an access finishes
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_wb_nxt        = r_wb_data;
    w_instr_out_nxt = NOP;
    w_mis_nxt       = 1'b0;
    w_err_nxt       = 1'b0;
    w_latch         = 1'b0;
    w_done          = 1'b0;
    stall_mem       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_issue) begin
          w_state_nxt = REQ;
          w_latch     = 1'b1;
          stall_mem   = 1'b1;
        end else if (w_misalign) begin
          w_mis_nxt = 1'b1;
        end else begin
          w_wb_nxt        = alu_res;
          w_instr_out_nxt = instr_in;
        end
      end
      REQ: begin
        stall_mem = 1'b1;
        if (dc_req_ready) begin
          if (dc_resp_valid) begin
            w_done = 1'b1;
          end else begin
            w_state_nxt = WAIT_RESP;
            w_cnt_nxt   = '0;
          end
        end
      end
      WAIT_RESP: begin
        stall_mem = 1'b1;
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (dc_resp_valid) begin
          w_done = 1'b1;
        end else if (r_cnt == CNT_LAST) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = IDLE;
          stall_mem   = 1'b0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_done) begin
      w_state_nxt     = IDLE;
      stall_mem       = 1'b0;
      w_wb_nxt        = r_we ? '0 : w_load_data;
      w_instr_out_nxt = r_instr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_be         <= '0;
      r_instr      <= NOP;
      r_we         <= 1'b0;
      r_wb_data    <= '0;
      r_instr_out  <= NOP;
      r_misaligned <= 1'b0;
      r_mem_err    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_wb_data    <= w_wb_nxt;
      r_instr_out  <= w_instr_out_nxt;
      r_misaligned <= w_mis_nxt;
      r_mem_err    <= w_err_nxt;
      if (w_latch) begin
        r_addr  <= alu_res;
        r_wdata <= w_wdata;
        r_be    <= w_be;
        r_instr <= instr_in;
        r_we    <= w_is_store;
      end
    end
  end

  assign dc_req_valid = (r_state == REQ);
  assign dc_req_we    = r_we;
  assign dc_req_addr  = r_addr;
  assign dc_req_wdata = r_wdata;
  assign dc_req_be    = r_be;
  assign wb_data      = r_wb_data;
  assign instr_out    = r_instr_out;
  assign misaligned   = r_misaligned;
  assign mem_err      = r_mem_err;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage; byte-access vectors run when MEM_BYTE_EN is defined.
module tb_mem_stage;
  import brisc_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  instr_in;
  logic [31:0] alu_res, rs2_data;
  logic        dc_req_valid, dc_req_we;
  logic [31:0] dc_req_addr, dc_req_wdata;
  logic [3:0]  dc_req_be;
  logic        dc_req_ready, dc_resp_valid;
  logic [31:0] dc_resp_rdata;
  logic        stall_mem;
  logic [31:0] wb_data;
  logic [4:0]  instr_out;
  logic        misaligned, mem_err;

  int n_checks = 0;
  int n_fail   = 0;

  mem_stage dut (
    .clk           (clk),
    .reset         (reset),
    .instr_in      (instr_in),
    .alu_res       (alu_res),
    .rs2_data      (rs2_data),
    .dc_req_valid  (dc_req_valid),
    .dc_req_we     (dc_req_we),
    .dc_req_addr   (dc_req_addr),
    .dc_req_wdata  (dc_req_wdata),
    .dc_req_be     (dc_req_be),
    .dc_req_ready  (dc_req_ready),
    .dc_resp_valid (dc_resp_valid),
    .dc_resp_rdata (dc_resp_rdata),
    .stall_mem     (stall_mem),
    .wb_data       (wb_data),
    .instr_out     (instr_out),
    .misaligned    (misaligned),
    .mem_err       (mem_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one access, accept it immediately, respond one cycle later
  task automatic access(input logic [4:0] ins, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rd, output logic [31:0] be_o, output logic [31:0] wd_o,
                        output logic [31:0] we_o);
    instr_in = ins;
    alu_res  = addr;
    rs2_data = wd;
    tick();
    check("acc_valid", 32'(dc_req_valid), 32'd1);
    check("acc_addr", dc_req_addr, addr);
    be_o = 32'(dc_req_be);
    wd_o = dc_req_wdata;
    we_o = 32'(dc_req_we);
    dc_req_ready = 1'b1;
    tick();
    dc_req_ready  = 1'b0;
    dc_resp_valid = 1'b1;
    dc_resp_rdata = rd;
    tick();
    dc_resp_valid = 1'b0;
    instr_in      = NOP;
    alu_res       = 32'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          stalls;
    int          n_to;
    logic        last_stall;
    logic [31:0] be_s, wd_s, we_s;

    reset = 1'b1; instr_in = NOP; alu_res = 32'h0; rs2_data = 32'h0;
    dc_req_ready = 1'b0; dc_resp_valid = 1'b0; dc_resp_rdata = 32'h0;
    tick(); tick();
    reset = 1'b0;
    #1;
    check("rst_wb", wb_data, 32'h0);
    check("rst_instr", 32'(instr_out), 32'(NOP));
    check("rst_mis", 32'(misaligned), 32'd0);
    check("rst_err", 32'(mem_err), 32'd0);
    check("rst_valid", 32'(dc_req_valid), 32'd0);
    check("rst_stall", 32'(stall_mem), 32'd0);

    // Non-memory pass-through
    instr_in = ADD; alu_res = 32'h0000_0042;
    #1 check("add_stall", 32'(stall_mem), 32'd0);
    tick();
    check("add_wb", wb_data, 32'h42);
    check("add_instr", 32'(instr_out), 32'(ADD));
    instr_in = NOP; alu_res = 32'h0;
    tick();

    // LW with ready held low 3 cycles, early response ignored, response 2 cycles after accept
    instr_in = LW; alu_res = 32'h0000_0100; rs2_data = 32'h1234_5678; stalls = 0;
    #1 if (stall_mem) stalls++;
    tick();
    check("lw_bubble", 32'(instr_out), 32'(NOP));
    for (int c = 1; c <= 4; c++) begin
      dc_req_ready  = (c == 4);
      dc_resp_valid = (c == 2);
      dc_resp_rdata = 32'hBAD0_0BAD;
      #1 if (stall_mem) stalls++;
      check("lw_req_valid", 32'(dc_req_valid), 32'd1);
      check("lw_req_addr", dc_req_addr, 32'h100);
      check("lw_req_be", 32'(dc_req_be), 32'hF);
      check("lw_req_we", 32'(dc_req_we), 32'd0);
      tick();
    end
    dc_req_ready = 1'b0; dc_resp_valid = 1'b0;
    #1 if (stall_mem) stalls++;
    check("lw_valid_drop", 32'(dc_req_valid), 32'd0);
    tick();
    dc_resp_valid = 1'b1; dc_resp_rdata = 32'hDEAD_BEEF;
    #1 if (stall_mem) stalls++;
    tick();
    dc_resp_valid = 1'b0; instr_in = NOP; alu_res = 32'h0;
    check("lw_wb", wb_data, 32'hDEAD_BEEF);
    check("lw_instr", 32'(instr_out), 32'(LW));
    check("lw_stalls", 32'(stalls), 32'd6);

    // Misaligned SW after an ADD
    instr_in = ADD; alu_res = 32'h7;
    tick();
    instr_in = SW; alu_res = 32'h0000_0103; rs2_data = 32'h55;
    #1 check("mis_stall", 32'(stall_mem), 32'd0);
    tick();
    check("mis_flag", 32'(misaligned), 32'd1);
    check("mis_instr", 32'(instr_out), 32'(NOP));
    check("mis_valid", 32'(dc_req_valid), 32'd0);
    instr_in = NOP; alu_res = 32'h0;
    tick();
    check("mis_pulse", 32'(misaligned), 32'd0);
    check("mis_valid2", 32'(dc_req_valid), 32'd0);

    // Ready and response in the same REQ cycle
    instr_in = LW; alu_res = 32'h0000_0104;
    tick();
    dc_req_ready = 1'b1; dc_resp_valid = 1'b1; dc_resp_rdata = 32'hCAFE_0001;
    tick();
    dc_req_ready = 1'b0; dc_resp_valid = 1'b0; instr_in = NOP; alu_res = 32'h0;
    check("dir_wb", wb_data, 32'hCAFE_0001);
    check("dir_instr", 32'(instr_out), 32'(LW));
    check("dir_valid", 32'(dc_req_valid), 32'd0);

    // Aligned word store
    access(SW, 32'h0000_0108, 32'h1122_3344, 32'h9999_9999, be_s, wd_s, we_s);
    check("sw_be", be_s, 32'hF);
    check("sw_wdata", wd_s, 32'h1122_3344);
    check("sw_we", we_s, 32'd1);
    check("sw_wb", wb_data, 32'h0);
    check("sw_instr", 32'(instr_out), 32'(SW));

    // Response timeout
    instr_in = LW; alu_res = 32'h0000_0200;
    tick();
    dc_req_ready = 1'b1;
    tick();
    dc_req_ready = 1'b0;
    #1 check("to_stall", 32'(stall_mem), 32'd1);
    n_to = 0; last_stall = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      last_stall = stall_mem;
      tick();
      if (mem_err) begin
        n_to = i;
        break;
      end
    end
    instr_in = NOP; alu_res = 32'h0;
    check("to_cycles", 32'(n_to), 32'd64);
    check("to_last_stall", 32'(last_stall), 32'd0);
    check("to_err", 32'(mem_err), 32'd1);
    check("to_instr", 32'(instr_out), 32'(NOP));
    tick();
    check("to_pulse", 32'(mem_err), 32'd0);
    check("to_stall_drop", 32'(stall_mem), 32'd0);
    check("to_valid", 32'(dc_req_valid), 32'd0);

    // Reset while waiting, then a stray response
    instr_in = LW; alu_res = 32'h0000_0300;
    tick();
    dc_req_ready = 1'b1;
    tick();
    dc_req_ready = 1'b0; instr_in = NOP; alu_res = 32'h0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rw_valid", 32'(dc_req_valid), 32'd0);
    dc_resp_valid = 1'b1; dc_resp_rdata = 32'h0000_0055;
    tick();
    dc_resp_valid = 1'b0;
    check("rw_wb", wb_data, 32'h0);
    check("rw_instr", 32'(instr_out), 32'(NOP));
    check("rw_stall", 32'(stall_mem), 32'd0);
    check("rw_err", 32'(mem_err), 32'd0);

`ifdef MEM_BYTE_EN
    access(LB, 32'h0000_0202, 32'h0, 32'h0080_0000, be_s, wd_s, we_s);
    check("lb_be", be_s, 32'h4);
    check("lb_wb", wb_data, 32'hFFFF_FF80);
    check("lb_instr", 32'(instr_out), 32'(LB));
    access(LBU, 32'h0000_0202, 32'h0, 32'h0080_0000, be_s, wd_s, we_s);
    check("lbu_wb", wb_data, 32'h0000_0080);
    access(SB, 32'h0000_0201, 32'h0000_00AB, 32'h0, be_s, wd_s, we_s);
    check("sb_be", be_s, 32'h2);
    check("sb_wdata", wd_s, 32'hABAB_ABAB);
    check("sb_we", we_s, 32'd1);
    check("sb_wb", wb_data, 32'h0);
`else
    instr_in = LB; alu_res = 32'h0000_0202;
    #1 check("lb_pt_stall", 32'(stall_mem), 32'd0);
    tick();
    check("lb_pt_valid", 32'(dc_req_valid), 32'd0);
    check("lb_pt_wb", wb_data, 32'h0000_0202);
    check("lb_pt_instr", 32'(instr_out), 32'(LB));
    instr_in = NOP; alu_res = 32'h0;
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
